tmds_rx_word_align: RTL and testbench

//  Receive-side counterpart of the 10:1 DDR TMDS serializer. Takes raw 10-bit words from a per-lane
//  1:10 ISERDES (arbitrary bit phase), finds word boundary by hunting DVI/HDMI control tokens in blanking,

---
 rtl/tmds_rx_pkg.sv | 21 ++
 rtl/tmds_rx_word_align_if.sv | 24 ++
 rtl/tmds_ctl_token_det.sv | 23 ++
 rtl/tmds_rx_word_align.sv | 130 +++++++++++++
 tb/tb_tmds_rx_word_align.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/tmds_rx_pkg.sv
// Shared definitions for the TMDS receive word aligner and control-token detector.
// Token values are the DVI/HDMI control symbols as they appear on the aligned 10-bit bus.
package tmds_rx_pkg;

    localparam logic [9:0] CTL_TOKEN_00 = 10'h354;
    localparam logic [9:0] CTL_TOKEN_01 = 10'h0AB;
    localparam logic [9:0] CTL_TOKEN_10 = 10'h154;
    localparam logic [9:0] CTL_TOKEN_11 = 10'h2AB;

    localparam logic [3:0] OFFSET_MAX = 4'd9;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } align_state_e;

    function automatic logic [3:0] next_offset(input logic [3:0] cur);
        return (cur >= OFFSET_MAX) ? 4'd0 : cur + 4'd1;
    endfunction

endpackage

// File: rtl/tmds_rx_word_align_if.sv
// Per-lane bus between the ISERDES/resync source and the word aligner.
// The master side supplies raw words and resync; the slave side returns aligned symbols and status.
interface tmds_rx_word_align_if;

    logic [9:0] rxdata;
    logic       resync;
    logic [9:0] dout;
    logic       dout_vld;
    logic       locked;
    logic [3:0] offset;
    logic       ctl_det;
    logic [1:0] ctl;

    modport master (
        output rxdata, resync,
        input  dout, dout_vld, locked, offset, ctl_det, ctl
    );

    modport slave (
        input  rxdata, resync,
        output dout, dout_vld, locked, offset, ctl_det, ctl
    );

endinterface

// File: rtl/tmds_ctl_token_det.sv
// Recognises the four TMDS control tokens on an aligned symbol and returns {C1,C0}.
// Purely combinational so the TMDS decoder can reuse it unchanged.
module tmds_ctl_token_det
    import tmds_rx_pkg::*;
(
    input  logic [9:0] sym,
    output logic       ctl_det,
    output logic [1:0] ctl
);

    always_comb begin
        ctl_det = 1'b1;
        ctl     = 2'b00;
        case (sym)
            CTL_TOKEN_00: ctl = 2'b00;
            CTL_TOKEN_01: ctl = 2'b01;
            CTL_TOKEN_10: ctl = 2'b10;
            CTL_TOKEN_11: ctl = 2'b11;
            default:      ctl_det = 1'b0;
        endcase
    end

endmodule

// File: rtl/tmds_rx_word_align.sv
// TMDS receive word aligner: hunts control tokens across the ten bit offsets of the raw
// ISERDES words, then holds lock until tokens vanish for too long or resync is pulsed.
module tmds_rx_word_align
    import tmds_rx_pkg::*;
#(
    parameter int LOCK_CNT       = 64,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int LOSS_TIMEOUT   = 8192,
    parameter int CNT_W          = 14
) (
    input  logic                 pclk,
    input  logic                 rxrst,
    tmds_rx_word_align_if.slave  bus
);

    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_CNT - 1);
    localparam logic [CNT_W-1:0] SEARCH_LAST = CNT_W'(SEARCH_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOSS_LAST   = CNT_W'(LOSS_TIMEOUT - 1);

    align_state_e     state, state_nxt;
    logic [3:0]       offset, offset_nxt;
    logic [CNT_W-1:0] tmr, tmr_nxt;
    logic [CNT_W-1:0] run, run_nxt;
    logic             settle, settle_nxt;
    logic [9:0]       q1, q2;
    logic [9:0]       aligned, aligned_nxt;
    logic [18:0]      cat;
    logic             ctl_det;
    logic [1:0]       ctl;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // The newest word's MSB is never selected (offset tops out at 9), so it is left out of the window.
    assign cat = {q1[8:0], q2};

    always_comb begin
        aligned_nxt = cat[9:0];
        for (int i = 0; i < 10; i++) begin
            if (offset == 4'(i)) aligned_nxt = cat[i +: 10];
        end
    end

    always_ff @(posedge pclk or posedge rxrst) begin
        if (rxrst) begin
            q1      <= '0;
            q2      <= '0;
            aligned <= '0;
        end else begin
            q1      <= bus.rxdata;
            q2      <= q1;
            aligned <= aligned_nxt;
        end
    end

    tmds_ctl_token_det u_token_det (
        .sym     (aligned),
        .ctl_det (ctl_det),
        .ctl     (ctl)
    );

    always_ff @(posedge pclk or posedge rxrst) begin
        if (rxrst) begin
            state  <= SEARCH;
            offset <= '0;
            tmr    <= '0;
            run    <= '0;
            settle <= 1'b0;
        end else begin
            state  <= state_nxt;
            offset <= offset_nxt;
            tmr    <= tmr_nxt;
            run    <= run_nxt;
            settle <= settle_nxt;
        end
    end

    // settle marks the one symbol still built with the previous offset, which must not count toward lock.
    always_comb begin
        state_nxt  = state;
        offset_nxt = offset;
        tmr_nxt    = tmr;
        run_nxt    = run;
        settle_nxt = 1'b0;
        if (bus.resync) begin
            state_nxt  = SEARCH;
            offset_nxt = next_offset(offset);
            tmr_nxt    = '0;
            run_nxt    = '0;
            settle_nxt = 1'b1;
        end else begin
            case (state)
                SEARCH: begin
                    tmr_nxt = sat_inc(tmr);
                    run_nxt = (ctl_det && !settle) ? sat_inc(run) : '0;
                    if (ctl_det && !settle && run >= LOCK_LAST) begin
                        state_nxt = LOCKED;
                        tmr_nxt   = '0;
                        run_nxt   = '0;
                    end else if (tmr >= SEARCH_LAST) begin
                        offset_nxt = next_offset(offset);
                        tmr_nxt    = '0;
                        run_nxt    = '0;
                        settle_nxt = 1'b1;
                    end
                end
                LOCKED: begin
                    tmr_nxt = ctl_det ? '0 : sat_inc(tmr);
                    if (tmr >= LOSS_LAST) begin
                        state_nxt  = SEARCH;
                        offset_nxt = next_offset(offset);
                        tmr_nxt    = '0;
                        run_nxt    = '0;
                        settle_nxt = 1'b1;
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end
    end

    assign bus.dout     = aligned;
    assign bus.locked   = (state == LOCKED);
    assign bus.dout_vld = (state == LOCKED);
    assign bus.offset   = offset;
    assign bus.ctl_det  = ctl_det;
    assign bus.ctl      = ctl;

endmodule

// File: tb/tb_tmds_rx_word_align.sv
// Directed bench for the TMDS word aligner: a serial token/data stream is regrouped at a chosen
// bit phase into raw words, and lock timing, offset stepping, resync and async reset are checked.
module tb_tmds_rx_word_align;
    import tmds_rx_pkg::*;

    logic pclk  = 1'b0;
    logic rxrst = 1'b1;
    int   passed = 0;
    int   total  = 0;
    logic [9:0] prev_sym = '0;

    tmds_rx_word_align_if bus ();

    tmds_rx_word_align dut (
        .pclk  (pclk),
        .rxrst (rxrst),
        .bus   (bus.slave)
    );

    always #5 pclk = ~pclk;

    // Drives n raw words carrying symbol s at bit phase p; each call step ends on a falling edge.
    task automatic apply_stimulus(input logic [9:0] s, input int p, input logic rs, input int n);
        logic [19:0] pair;
        for (int k = 0; k < n; k++) begin
            pair = {s, prev_sym} >> (10 - p);
            bus.rxdata = pair[9:0];
            bus.resync = rs;
            prev_sym   = s;
            @(posedge pclk);
            @(negedge pclk);
        end
        bus.resync = 1'b0;
    endtask

    task automatic check_output(input string tag, input logic [9:0] observed, input logic [9:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s: observed 0x%03h expected 0x%03h", tag, observed, expected);
    endtask

    task automatic reset_dut();
        rxrst      = 1'b1;
        bus.rxdata = '0;
        bus.resync = 1'b0;
        prev_sym   = '0;
        @(negedge pclk);
        @(negedge pclk);
        rxrst = 1'b0;
    endtask

    initial begin
        bus.rxdata = '0;
        bus.resync = 1'b0;
        @(negedge pclk);
        reset_dut();
        $display("[TB] reset state");
        check_output("rst_dout", bus.dout, 10'h000);
        check_output("rst_locked", 10'(bus.locked), 10'd0);
        check_output("rst_dout_vld", 10'(bus.dout_vld), 10'd0);
        check_output("rst_offset", 10'(bus.offset), 10'd0);
        check_output("rst_ctl_det", 10'(bus.ctl_det), 10'd0);
        check_output("rst_ctl", 10'(bus.ctl), 10'd0);

        $display("[TB] phase 0 lock on 0x354");
        apply_stimulus(10'h354, 0, 1'b0, 66);
        check_output("t1_locked_early", 10'(bus.locked), 10'd0);
        apply_stimulus(10'h354, 0, 1'b0, 1);
        check_output("t1_locked", 10'(bus.locked), 10'd1);
        check_output("t1_dout_vld", 10'(bus.dout_vld), 10'd1);
        check_output("t1_offset", 10'(bus.offset), 10'd0);
        check_output("t1_dout", bus.dout, 10'h354);
        check_output("t1_ctl_det", 10'(bus.ctl_det), 10'd1);
        check_output("t1_ctl", 10'(bus.ctl), 10'd0);

        $display("[TB] loss of tokens while locked");
        apply_stimulus(10'h000, 0, 1'b0, 8194);
        check_output("t3_locked_hold", 10'(bus.locked), 10'd1);
        apply_stimulus(10'h000, 0, 1'b0, 1);
        check_output("t3_locked_drop", 10'(bus.locked), 10'd0);
        check_output("t3_dout_vld_drop", 10'(bus.dout_vld), 10'd0);
        check_output("t3_offset", 10'(bus.offset), 10'd1);
        apply_stimulus(10'h154, 1, 1'b0, 66);
        check_output("t3_relock_early", 10'(bus.locked), 10'd0);
        apply_stimulus(10'h154, 1, 1'b0, 1);
        check_output("t3_relock", 10'(bus.locked), 10'd1);
        check_output("t3_relock_offset", 10'(bus.offset), 10'd1);
        check_output("t3_relock_dout", bus.dout, 10'h154);
        check_output("t3_relock_ctl", 10'(bus.ctl), 10'd2);

        $display("[TB] resync");
        apply_stimulus(10'h154, 1, 1'b1, 1);
        check_output("t4_locked", 10'(bus.locked), 10'd0);
        check_output("t4_offset", 10'(bus.offset), 10'd2);
        apply_stimulus(10'h154, 1, 1'b1, 7);
        check_output("t4_offset9", 10'(bus.offset), 10'd9);
        apply_stimulus(10'h154, 1, 1'b1, 1);
        check_output("t4_offset_wrap", 10'(bus.offset), 10'd0);
        check_output("t4_locked_wrap", 10'(bus.locked), 10'd0);

        $display("[TB] async reset mid-search");
        reset_dut();
        apply_stimulus(10'h354, 0, 1'b1, 5);
        apply_stimulus(10'h354, 0, 1'b0, 4);
        check_output("t6_offset_pre", 10'(bus.offset), 10'd5);
        check_output("t6_dout_pre", bus.dout, 10'h29A);
        #2 rxrst = 1'b1;
        #1;
        check_output("t6_dout", bus.dout, 10'h000);
        check_output("t6_offset", 10'(bus.offset), 10'd0);
        check_output("t6_locked", 10'(bus.locked), 10'd0);
        check_output("t6_dout_vld", 10'(bus.dout_vld), 10'd0);
        check_output("t6_ctl_det", 10'(bus.ctl_det), 10'd0);
        check_output("t6_ctl", 10'(bus.ctl), 10'd0);
        @(negedge pclk);

        $display("[TB] lock and search timeout in the same cycle");
        reset_dut();
        apply_stimulus(10'h000, 0, 1'b0, 4029);
        apply_stimulus(10'h2AB, 0, 1'b0, 66);
        check_output("t5_locked_early", 10'(bus.locked), 10'd0);
        check_output("t5_offset_early", 10'(bus.offset), 10'd0);
        apply_stimulus(10'h2AB, 0, 1'b0, 1);
        check_output("t5_locked", 10'(bus.locked), 10'd1);
        check_output("t5_offset", 10'(bus.offset), 10'd0);
        check_output("t5_ctl", 10'(bus.ctl), 10'd3);

        $display("[TB] phase 7 search on 0x0AB");
        reset_dut();
        apply_stimulus(10'h0AB, 7, 1'b0, 4095);
        check_output("t2_offset0", 10'(bus.offset), 10'd0);
        apply_stimulus(10'h0AB, 7, 1'b0, 1);
        check_output("t2_offset1", 10'(bus.offset), 10'd1);
        apply_stimulus(10'h0AB, 7, 1'b0, 28736 - 4096);
        check_output("t2_offset7", 10'(bus.offset), 10'd7);
        check_output("t2_locked_early", 10'(bus.locked), 10'd0);
        apply_stimulus(10'h0AB, 7, 1'b0, 1);
        check_output("t2_locked", 10'(bus.locked), 10'd1);
        check_output("t2_offset", 10'(bus.offset), 10'd7);
        check_output("t2_dout", bus.dout, 10'h0AB);
        check_output("t2_ctl", 10'(bus.ctl), 10'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
